// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter (00-99) with prescaled tick, start/stop toggle and sync clear.
// Boundary behaviour: saturate by default; define COUNTER_WRAP_EN for 99<->00 wrap-around.
module bcd_updown_counter #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned TICK_W   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       dir,
  input  logic       clr,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0,
  output logic       running
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [TICK_W-1:0] TickLast = TICK_W'(TICK_DIV - 1);

  state_e            state_q;
  logic [TICK_W-1:0] presc_q;
  logic              btn_q;
  logic              start_pulse;
  logic              tick;
  logic [3:0]        bcd1_d;
  logic [3:0]        bcd0_d;

  assign start_pulse = start_btn & ~btn_q;
  assign tick        = (state_q == StRun) && (presc_q == TickLast);

  // Next count value, applied only on a tick.
  always_comb begin
    bcd1_d = BCD1;
    bcd0_d = BCD0;
    if (dir) begin
      if (BCD0 != 4'd9) begin
        bcd0_d = BCD0 + 4'd1;
      end else if (BCD1 != 4'd9) begin
        bcd0_d = 4'd0;
        bcd1_d = BCD1 + 4'd1;
      end else begin
`ifdef COUNTER_WRAP_EN
        bcd0_d = 4'd0;
        bcd1_d = 4'd0;
`else
        bcd0_d = 4'd9;
        bcd1_d = 4'd9;
`endif
      end
    end else begin
      if (BCD0 != 4'd0) begin
        bcd0_d = BCD0 - 4'd1;
      end else if (BCD1 != 4'd0) begin
        bcd0_d = 4'd9;
        bcd1_d = BCD1 - 4'd1;
      end else begin
`ifdef COUNTER_WRAP_EN
        bcd0_d = 4'd9;
        bcd1_d = 4'd9;
`else
        bcd0_d = 4'd0;
        bcd1_d = 4'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      running <= 1'b0;
      presc_q <= '0;
      btn_q   <= 1'b0;
      BCD1    <= 4'd0;
      BCD0    <= 4'd0;
    end else begin
      btn_q <= start_btn;
      // Clear wins over a coincident tick; the tick is dropped.
      if (clr) begin
        BCD1    <= 4'd0;
        BCD0    <= 4'd0;
        presc_q <= '0;
      end else if (state_q == StRun) begin
        if (tick) begin
          presc_q <= '0;
          BCD1    <= bcd1_d;
          BCD0    <= bcd0_d;
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
      if (start_pulse) begin
        state_q <= (state_q == StRun) ? StIdle : StRun;
        running <= (state_q == StIdle);
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: integer-count reference model compared every
// cycle, plus directed literal checks. Honours COUNTER_WRAP_EN for boundary expectations.
module tb_bcd_updown_counter;

  localparam int TickDiv = 4;
`ifdef COUNTER_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_btn = 1'b0;
  logic       dir = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       running;

  int checks = 0;
  int failures = 0;
  bit en_cmp = 1'b0;

  // Reference model: count as a plain integer 0..99.
  int m_count = 0;
  int m_pre = 0;
  bit m_run = 1'b0;
  bit m_btn = 1'b0;

  bcd_updown_counter #(
    .TICK_DIV(TickDiv),
    .TICK_W  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_btn(start_btn),
    .dir      (dir),
    .clr      (clr),
    .BCD1     (BCD1),
    .BCD0     (BCD0),
    .running  (running)
  );

  always #5 clk = ~clk;

  function automatic int next_count(int c, bit up);
    if (up) return (c == 99) ? (Wrap ? 0 : 99) : c + 1;
    else    return (c == 0)  ? (Wrap ? 99 : 0) : c - 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_pre   <= 0;
      m_run   <= 1'b0;
      m_btn   <= 1'b0;
    end else begin
      m_btn <= start_btn;
      if (clr) begin
        m_count <= 0;
        m_pre   <= 0;
      end else if (m_run) begin
        if (m_pre == TickDiv - 1) begin
          m_pre   <= 0;
          m_count <= next_count(m_count, dir);
        end else begin
          m_pre <= m_pre + 1;
        end
      end
      if (start_btn && !m_btn) m_run <= !m_run;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input int exp_cnt, input int exp_run);
    check({name, "_bcd"}, 10 * int'(BCD1) + int'(BCD0), exp_cnt);
    check({name, "_run"}, int'(running), exp_run);
  endtask

  always @(negedge clk) begin
    if (en_cmp) begin
      check("model_bcd1", int'(BCD1), m_count / 10);
      check("model_bcd0", int'(BCD0), m_count % 10);
      check("model_running", int'(running), int'(m_run));
    end
  end

  task automatic press();
    @(negedge clk) start_btn = 1'b1;
    @(negedge clk) start_btn = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  // Returns at the first negedge where the model shows value v.
  task automatic wait_count(input int v);
    for (int i = 0; i < 2000; i++) begin
      if (m_count == v) return;
      @(negedge clk);
    end
    check("wait_count_timeout", m_count, v);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt("reset", 0, 0);
    rst_n  = 1'b1;
    en_cmp = 1'b1;

    // Entry and first ticks.
    press();
    check("run_entry", int'(running), 1);
    repeat (3) @(negedge clk);
    check_cnt("pre_first_tick", 0, 1);
    @(negedge clk);
    check_cnt("tick1", 1, 1);
    repeat (4) @(negedge clk);
    check_cnt("tick2", 2, 1);
    repeat (4) @(negedge clk);
    check_cnt("tick3", 3, 1);

    // Digit carry and borrow.
    wait_count(9);
    repeat (4) @(negedge clk);
    check_cnt("up_9_to_10", 10, 1);
    dir = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt("down_10_to_9", 9, 1);
    dir = 1'b1;

    // Boundaries.
    wait_count(99);
    repeat (4) @(negedge clk);
    check_cnt("boundary_up", Wrap ? 0 : 99, 1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    dir = 1'b0;
    repeat (4) @(negedge clk);
    check_cnt("boundary_down", Wrap ? 99 : 0, 1);
    dir = 1'b1;

    // Held button toggles once; pause then resume.
    @(negedge clk) start_btn = 1'b1;
    repeat (20) @(negedge clk);
    start_btn = 1'b0;
    check("hold_one_toggle", int'(running), 0);
    press();
    check("resume", int'(running), 1);
    repeat (6) @(negedge clk);
    press();
    check("pause", int'(running), 0);
    repeat (50) @(negedge clk);
    press();
    repeat (10) @(negedge clk);

    // Clear on a tick cycle at 37.
    pulse_clr();
    wait_count(37);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check_cnt("clr_on_tick", 0, 1);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    start_btn = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    start_btn = 1'b0;
    check_cnt("clr_with_start", 0, 0);

    // Asynchronous reset mid-count at 42.
    press();
    wait_count(42);
    #2 rst_n = 1'b0;
    #1 check_cnt("async_reset", 0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_cnt("no_count_after_reset", 0, 0);
    press();
    repeat (4) @(negedge clk);
    check_cnt("restart", 1, 1);
    repeat (8) @(negedge clk);

    en_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
